data_sram_bridge: RTL and testbench

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

---
 rtl/data_sram_bridge.sv | 150 +++++++++++++++
 tb/tb_data_sram_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Data-side bridge from the core's ME-stage SRAM-style access to a req/addr_ok/data_ok bus.
// Optional DATA_SRAM_BRIDGE_KSEG_MAP_EN clears bits [31:29] of 0x8000_0000-0xBFFF_FFFF addresses.
module data_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_flush,
  input  logic        pipe_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nx;
  logic        cancel_r;
  logic        cancel_now_s;
  logic        start_s;
  logic [31:0] addr_cap_s;

  function automatic logic [1:0] size_of(input logic [3:0] wen);
    logic [1:0] sz;
    case (wen)
      4'b0011, 4'b1100:                   sz = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
      default:                            sz = 2'd2;
    endcase
    return sz;
  endfunction

  // Reads yield 0 here, which gives the word-aligned read address.
  function automatic logic [1:0] low_of(input logic [3:0] wen);
    logic [1:0] lo;
    if (wen[0])      lo = 2'd0;
    else if (wen[1]) lo = 2'd1;
    else if (wen[2]) lo = 2'd2;
    else if (wen[3]) lo = 2'd3;
    else             lo = 2'd0;
    return lo;
  endfunction

  function automatic logic [31:0] map_addr(input logic [31:0] addr);
    logic [31:0] m;
`ifdef DATA_SRAM_BRIDGE_KSEG_MAP_EN
    if (addr[31:30] == 2'b10) m = {3'b000, addr[28:0]};
    else                      m = addr;
`else
    m = addr;
`endif
    return m;
  endfunction

  assign start_s      = cpu_en && !cpu_flush;
  assign cancel_now_s = cancel_r || cpu_flush;
  assign addr_cap_s   = (map_addr(cpu_addr) & 32'hFFFF_FFFC) | {30'd0, low_of(cpu_wen)};

  // Next-state decode and the data-side stall to the core.
  always_comb begin
    state_nx  = state_r;
    cpu_stall = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nx  = ADDR;
          cpu_stall = 1'b1;
        end else begin
          state_nx  = IDLE;
        end
      end
      ADDR: begin
        cpu_stall = 1'b1;
        if (data_addr_ok) state_nx = DATA;
        else              state_nx = ADDR;
      end
      DATA: begin
        cpu_stall = 1'b1;
        if (data_data_ok) state_nx = cancel_now_s ? IDLE : HOLD;
        else              state_nx = DATA;
      end
      HOLD: begin
        if (!pipe_stall || cpu_flush) state_nx = IDLE;
        else                          state_nx = HOLD;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, captured bus fields, cancel flag and load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cancel_r   <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
      cpu_rdata  <= 32'd0;
    end else begin
      state_r <= state_nx;
      if (state_nx == IDLE)
        cancel_r <= 1'b0;
      else if ((state_r == ADDR || state_r == DATA) && cpu_flush)
        cancel_r <= 1'b1;
      else
        cancel_r <= cancel_r;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            data_req   <= 1'b1;
            data_wr    <= (cpu_wen != 4'b0000);
            data_size  <= size_of(cpu_wen);
            data_addr  <= addr_cap_s;
            data_wdata <= cpu_wdata;
          end
        end
        ADDR: begin
          if (data_addr_ok) data_req <= 1'b0;
        end
        DATA: begin
          // A cancelled load still drains the bus but never reaches the core.
          if (data_data_ok && !data_wr && !cancel_now_s) cpu_rdata <= data_rdata;
        end
        default: begin
          data_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed, table-driven bench for data_sram_bridge plus hand sequences for flush, hold and reset.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_flush;
  logic        pipe_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  data_sram_bridge dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush), .pipe_stall(pipe_stall),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );

`ifdef DATA_SRAM_BRIDGE_KSEG_MAP_EN
  localparam logic [31:0] KSEG_EXP = 32'h0000_0010;
`else
  localparam logic [31:0] KSEG_EXP = 32'hA000_0010;
`endif

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          delay;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    cpu_en = 1'b1; cpu_wen = v.wen; cpu_addr = v.addr; cpu_wdata = v.wdata;
    #1 chk("stall_on_request", {31'd0, cpu_stall}, 32'd1);
    @(negedge clk);
    cpu_en = 1'b0; cpu_wen = 4'b0000; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    chk("req", {31'd0, data_req}, 32'd1);
    chk("wr", {31'd0, data_wr}, {31'd0, v.exp_wr});
    chk("size", {30'd0, data_size}, {30'd0, v.exp_size});
    chk("addr", data_addr, v.exp_addr);
    chk("wdata", data_wdata, v.wdata);
    for (int k = 0; k < v.delay; k++) begin
      data_data_ok = (k == 0);
      @(negedge clk);
      data_data_ok = 1'b0;
      chk("req_held", {31'd0, data_req}, 32'd1);
      chk("addr_held", data_addr, v.exp_addr);
      chk("size_held", {30'd0, data_size}, {30'd0, v.exp_size});
      chk("stall_in_addr", {31'd0, cpu_stall}, 32'd1);
    end
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    chk("req_dropped", {31'd0, data_req}, 32'd0);
    chk("stall_in_data", {31'd0, cpu_stall}, 32'd1);
    data_data_ok = 1'b1; data_rdata = v.bus_rdata;
    @(negedge clk);
    data_data_ok = 1'b0; data_rdata = 32'd0;
    chk("stall_released", {31'd0, cpu_stall}, 32'd0);
    chk("rdata", cpu_rdata, v.exp_rdata);
  endtask

  initial begin
    vecs[0] = '{4'b0000, 32'h0000_1004, 32'h1111_1111, 32'hDEAD_BEEF, 0, 1'b0, 2'd2, 32'h0000_1004, 32'hDEAD_BEEF};
    vecs[1] = '{4'b0000, 32'h0000_1007, 32'h2222_2222, 32'h0BAD_F00D, 3, 1'b0, 2'd2, 32'h0000_1004, 32'h0BAD_F00D};
    vecs[2] = '{4'b0100, 32'h0000_2000, 32'h00AB_0000, 32'hFFFF_FFFF, 0, 1'b1, 2'd0, 32'h0000_2002, 32'h0BAD_F00D};
    vecs[3] = '{4'b1111, 32'h0000_3000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, 1'b1, 2'd2, 32'h0000_3000, 32'h0BAD_F00D};
    vecs[4] = '{4'b0011, 32'h0000_4003, 32'h0000_BEEF, 32'hFFFF_FFFF, 0, 1'b1, 2'd1, 32'h0000_4000, 32'h0BAD_F00D};
    vecs[5] = '{4'b1100, 32'h0000_4000, 32'hBEEF_0000, 32'hFFFF_FFFF, 0, 1'b1, 2'd1, 32'h0000_4002, 32'h0BAD_F00D};
    vecs[6] = '{4'b1000, 32'h0000_5000, 32'h7700_0000, 32'hFFFF_FFFF, 0, 1'b1, 2'd0, 32'h0000_5003, 32'h0BAD_F00D};
    vecs[7] = '{4'b0110, 32'h0000_6000, 32'h0012_3400, 32'hFFFF_FFFF, 0, 1'b1, 2'd2, 32'h0000_6001, 32'h0BAD_F00D};
    vecs[8] = '{4'b0000, 32'hA000_0010, 32'h0, 32'h55AA_55AA, 0, 1'b0, 2'd2, KSEG_EXP, 32'h55AA_55AA};

    rst = 1'b0; cpu_en = 1'b0; cpu_wen = 4'b0000; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    cpu_flush = 1'b0; pipe_stall = 1'b0; data_addr_ok = 1'b0; data_rdata = 32'd0; data_data_ok = 1'b0;
    #12;
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_size_wr", {29'd0, data_size, data_wr}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Flush in DATA: bus completes, load dropped, straight back to IDLE.
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = 32'h0000_0100;
    @(negedge clk);
    cpu_en = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; cpu_flush = 1'b1;
    #1 chk("flush_data_stall", {31'd0, cpu_stall}, 32'd1);
    @(negedge clk);
    cpu_flush = 1'b0;
    chk("cancel_stall_held", {31'd0, cpu_stall}, 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678; pipe_stall = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("cancel_stall_off", {31'd0, cpu_stall}, 32'd0);
    chk("cancel_rdata_kept", cpu_rdata, 32'h55AA_55AA);
    cpu_en = 1'b1; cpu_flush = 1'b1;
    #1 chk("cancel_in_idle_flushed", {31'd0, cpu_stall}, 32'd0);
    cpu_flush = 1'b0;
    #1 chk("cancel_in_idle", {31'd0, cpu_stall}, 32'd1);
    cpu_en = 1'b0; pipe_stall = 1'b0;

    // HOLD under pipe_stall: no reissue, leaves when pipe_stall drops.
    begin
      int reqs;
      reqs = 0;
      @(negedge clk);
      cpu_en = 1'b1; cpu_wen = 4'b0001; cpu_addr = 32'h0000_7000; cpu_wdata = 32'h0000_00EE;
      @(negedge clk);
      cpu_en = 1'b0; cpu_wen = 4'b0000;
      if (data_req) reqs++;
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      if (data_req) reqs++;
      data_data_ok = 1'b1; pipe_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        data_data_ok = 1'b0;
        if (data_req) reqs++;
        chk("hold_stall", {31'd0, cpu_stall}, 32'd0);
      end
      chk("hold_single_req", reqs, 32'd1);
      pipe_stall = 1'b0;
      @(negedge clk);
      cpu_en = 1'b1;
      #1 chk("hold_to_idle", {31'd0, cpu_stall}, 32'd1);
      cpu_en = 1'b0;
    end

    // Asynchronous reset in ADDR abandons the access.
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = 32'h0000_8000;
    @(negedge clk);
    cpu_en = 1'b0;
    chk("pre_reset_req", {31'd0, data_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, data_req}, 32'd0);
    chk("async_rst_addr", data_addr, 32'd0);
    chk("async_rst_rdata", cpu_rdata, 32'd0);
    chk("async_rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk("post_reset_idle", {30'd0, data_req, cpu_stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
